// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// operand width, iteration counter width and controller state encoding.
package mult_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    // Counter value loaded at start; the add-shift step with this counter at 0 is the last one
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_shift_reg.sv
// 33-bit partial product register P for the shift-and-add multiplier.
// The low half starts as the multiplier and is consumed one bit per step.
// The high half accumulates the product, with the adder carry entering at P[31].
module mult_shift_reg
    import mult_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_multiplicador,
    input  logic [WIDTH:0]     i_addSoma,
    output logic [2*WIDTH:0]   o_p,
    output logic [2*WIDTH:0]   o_pNext
);

    logic [2*WIDTH:0] r_p;
    logic [WIDTH:0]   w_s;
    logic [2*WIDTH:0] w_pStep;

    // Select the adder result when the current multiplier bit is set, then shift right by one
    always_comb begin
        w_s     = r_p[0] ? i_addSoma : {1'b0, r_p[2*WIDTH-1:WIDTH]};
        w_pStep = {1'b0, w_s, r_p[WIDTH-1:1]};
    end

    // P register: cleared on reset, loaded with the multiplier on start, add-shifted while calculating
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_p <= '0;
        end else if (i_load) begin
            r_p <= {{(WIDTH+1){1'b0}}, i_multiplicador};
        end else if (i_step) begin
            r_p <= w_pStep;
        end
    end

    assign o_p     = r_p;
    assign o_pNext = w_pStep;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier controller.
// Shares an external adder (AddA + AddB -> AddSoma) for one partial-product add per cycle.
// Optional feature macro MULT_ZERO_BYPASS_EN: a zero operand goes straight to DONE with result 0.
module mult_seq_ctrl
    import mult_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic [WIDTH-1:0]     AddA,
    output logic [WIDTH-1:0]     AddB,
    input  logic [WIDTH:0]       AddSoma,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Pronto,
    output logic                 Ocupado
);

    state_t               r_state;
    state_t               w_nextState;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_produto;
    logic                 r_pronto;

    logic                 w_load;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_zero;
    logic [2*WIDTH:0]     w_p;
    logic [2*WIDTH:0]     w_pNext;
    logic                 w_unusedBits;

    mult_shift_reg u_shiftReg (
        .i_clock         (Clock),
        .i_reset         (Reset),
        .i_load          (w_load),
        .i_step          (w_step),
        .i_multiplicador (Multiplicador),
        .i_addSoma       (AddSoma),
        .o_p             (w_p),
        .o_pNext         (w_pNext)
    );

    // Next-state and datapath control decode
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_zero      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_load = 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
                    if ((Multiplicando == '0) || (Multiplicador == '0)) begin
                        w_zero      = 1'b1;
                        w_nextState = DONE;
                    end else begin
                        w_nextState = CALC;
                    end
`else
                    w_nextState = CALC;
`endif
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, iteration counter, captured multiplicand, result and done pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_produto <= '0;
            r_pronto  <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_pronto <= w_finish | w_zero;
            if (w_load) begin
                r_mcand <= Multiplicando;
                r_cnt   <= CNT_LAST;
            end else if (w_step) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                r_produto <= w_pNext[2*WIDTH-1:0];
            end else if (w_zero) begin
                r_produto <= '0;
            end
        end
    end

    assign AddA    = w_p[2*WIDTH-1:WIDTH];
    assign AddB    = r_mcand;
    assign Produto = r_produto;
    assign Pronto  = r_pronto;
    assign Ocupado = (r_state != IDLE);

    // Bit 32 of P is always zero and the low half never feeds the adder
    assign w_unusedBits = ^{w_p[2*WIDTH], w_p[WIDTH-1:0], w_pNext[2*WIDTH]};

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl with a behavioural 17-bit adder.
// Honours MULT_ZERO_BYPASS_EN for the zero-operand latency expectation.
module tb_mult_seq_ctrl;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] Multiplicando;
    logic [15:0] Multiplicador;
    logic [15:0] AddA;
    logic [15:0] AddB;
    logic [16:0] AddSoma;
    logic [31:0] Produto;
    logic        Pronto;
    logic        Ocupado;

    int total = 0;
    int bad   = 0;

    mult_seq_ctrl dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Start         (Start),
        .Multiplicando (Multiplicando),
        .Multiplicador (Multiplicador),
        .AddA          (AddA),
        .AddB          (AddB),
        .AddSoma       (AddSoma),
        .Produto       (Produto),
        .Pronto        (Pronto),
        .Ocupado       (Ocupado)
    );

    // External adder shared with the multiplier
    assign AddSoma = {1'b0, AddA} + {1'b0, AddB};

    // 10 ns clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present operands and Start before an edge (called at a negedge); returns just after E0
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit hold);
        Multiplicando = a;
        Multiplicador = b;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        if (!hold) Start = 1'b0;
    endtask

    // Wait (bounded) for Pronto, then check latency, result, busy flag and single-cycle pulse
    task automatic waitDone(input string tag, input logic [31:0] expProduto, input int expLat);
        int lat = 0;
        int occLow = 0;
        @(negedge Clock);
        while (!Pronto && lat < 40) begin
            if (!Ocupado) occLow++;
            @(posedge Clock);
            lat++;
            @(negedge Clock);
        end
        checkOutput({tag, "/latency"}, lat, expLat);
        checkOutput({tag, "/produto"}, Produto, expProduto);
        checkOutput({tag, "/busyWhileCalc"}, occLow, 0);
        checkOutput({tag, "/busyInDone"}, {31'b0, Ocupado}, 1);
        @(posedge Clock);
        @(negedge Clock);
        checkOutput({tag, "/prontoOneCycle"}, {31'b0, Pronto}, 0);
        checkOutput({tag, "/idleAfter"}, {31'b0, Ocupado}, 0);
        checkOutput({tag, "/produtoHeld"}, Produto, expProduto);
    endtask

    initial begin
        int prontoCount;

        Reset = 1'b1;
        Start = 1'b0;
        Multiplicando = '0;
        Multiplicador = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkOutput("reset/produto", Produto, 0);
        checkOutput("reset/pronto", {31'b0, Pronto}, 0);
        checkOutput("reset/ocupado", {31'b0, Ocupado}, 0);
        checkOutput("reset/addA", {16'b0, AddA}, 0);
        Reset = 1'b0;
        @(negedge Clock);

        applyStimulus(16'd3, 16'd5, 1'b0);
        waitDone("3x5", 32'd15, 16);

        @(negedge Clock);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        waitDone("ffffxffff", 32'hFFFE0001, 16);

        // Start held high with different operands while busy must be ignored
        @(negedge Clock);
        applyStimulus(16'h1234, 16'h0001, 1'b1);
        Multiplicando = 16'hFFFF;
        Multiplicador = 16'hFFFF;
        waitDone("startIgnored", 32'h00001234, 16);
        Start = 1'b0;

        // Reset in the middle of an operation at E8
        @(negedge Clock);
        applyStimulus(16'd7, 16'd9, 1'b0);
        repeat (7) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        checkOutput("midReset/ocupado", {31'b0, Ocupado}, 0);
        checkOutput("midReset/produto", Produto, 0);
        checkOutput("midReset/pronto", {31'b0, Pronto}, 0);
        Reset = 1'b0;
        prontoCount = 0;
        repeat (25) begin
            @(negedge Clock);
            if (Pronto) prontoCount++;
        end
        checkOutput("midReset/noPronto", prontoCount, 0);

        // Zero operand: bypass finishes in the cycle after E0, otherwise full length
        @(negedge Clock);
        applyStimulus(16'd0, 16'h1234, 1'b0);
`ifdef MULT_ZERO_BYPASS_EN
        waitDone("zero", 32'd0, 0);
`else
        waitDone("zero", 32'd0, 16);
`endif

        // Back-to-back: second Start issued in the first IDLE cycle after E17
        @(negedge Clock);
        applyStimulus(16'd6, 16'd7, 1'b0);
        waitDone("6x7", 32'd42, 16);
        applyStimulus(16'd100, 16'd200, 1'b0);
        waitDone("100x200", 32'd20000, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
